// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO write-side arbiter.
//   arb_state_e     - arbiter FSM states
//   SRC_LSB/LAST_BIT - tag layout of a beat at the default widths
//   tagged_beat_t   - {src, last, data} beat at the default widths
//   last_bit/src_lsb - tag layout for an arbitrary payload width
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_N_REQ  = 4;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_SRC_W  = 2;

    // Beat layout, MSB first: {src, last, data}
    localparam int unsigned LAST_BIT = DEF_DATA_W;
    localparam int unsigned SRC_LSB  = DEF_DATA_W + 1;

    typedef struct packed {
        logic [DEF_SRC_W-1:0]  src;
        logic                  last;
        logic [DEF_DATA_W-1:0] data;
    } tagged_beat_t;

    function automatic int unsigned last_bit(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned src_lsb(input int unsigned data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority pick.
//   req_i   - request mask
//   ptr_i   - index with highest priority this cycle
//   found_o - at least one request set
//   idx_o   - first set request scanning ptr_i, ptr_i+1, ... mod N
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] shifted;
    logic [N-1:0]   rot;

    // Rotate the mask so that bit 0 is the pointer position; the scan is
    // then a plain lowest-set-bit search with the index mapped back.
    always_comb begin
        dbl     = {req_i, req_i};
        shifted = dbl >> ptr_i;
        rot     = shifted[N-1:0];
    end

    always_comb begin
        int unsigned pos;
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found_o && rot[k]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-atomic round-robin arbiter sharing the async_fifo
// write port between N_REQ requesters (write clock domain).
//   wr_clk, wr_rst_n    - clock, synchronous active-low reset
//   cfg_enable          - per-requester enable for new grants
//   req_valid/data/last - requester beat streams, req_ready back
//   fifo_wr_en/data     - registered FIFO write, data = {src, last, data}
//   fifo_wr_full        - FIFO full; write takes effect when en && !full
//   grant_active/idx    - packet grant status
//   pkt_count           - packets forwarded (wrapping)
//   stall_count         - cycles with en && full (saturating)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      wr_clk,
    input  logic                      wr_rst_n,
    input  logic [N_REQ-1:0]          cfg_enable,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      fifo_wr_en,
    output logic [SRC_W+1+DATA_W-1:0] fifo_wr_data,
    input  logic                      fifo_wr_full,
    output logic                      grant_active,
    output logic [SRC_W-1:0]          grant_idx,
    output logic [CNT_W-1:0]          pkt_count,
    output logic [CNT_W-1:0]          stall_count
);

    localparam int unsigned TAG_W  = SRC_W + 1 + DATA_W;
    localparam int unsigned LAST_B = last_bit(DATA_W);
    localparam int unsigned SRC_B  = src_lsb(DATA_W);

    arb_state_e        state_q, state_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]  grant_idx_q, grant_idx_d;
    logic              grant_active_q, grant_active_d;
    logic              wr_en_q, wr_en_d;
    logic [TAG_W-1:0]  wr_data_q, wr_data_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [N_REQ-1:0]  cand;
    logic              pick_found;
    logic [SRC_W-1:0]  pick_idx;

    logic              load;
    logic              accept;
    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;

    assign cand = req_valid & cfg_enable;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (SRC_W)
    ) u_rr_pick (
        .req_i   (cand),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // The output register can take a beat when it is empty or being drained
    // this edge; depends on registered state plus full, never on req_valid.
    assign load   = !wr_en_q || !fifo_wr_full;
    assign accept = (state_q == ARB_XFER) && g_valid && load;

    always_comb begin
        g_valid   = 1'b0;
        g_last    = 1'b0;
        g_data    = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_idx_q == SRC_W'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*DATA_W +: DATA_W];
                if (state_q == ARB_XFER) begin
                    req_ready[i] = load;
                end
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_idx_d    = grant_idx_q;
        grant_active_d = grant_active_q;
        pkt_cnt_d      = pkt_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_idx_d    = pick_idx;
                    grant_active_d = 1'b1;
                    state_d        = ARB_XFER;
                end
            end
            ARB_XFER: begin
                if (accept && g_last) begin
                    state_d        = ARB_IDLE;
                    grant_active_d = 1'b0;
                    rr_ptr_d       = (32'(grant_idx_q) == N_REQ - 1) ? '0
                                   : grant_idx_q + SRC_W'(1);
                    pkt_cnt_d      = pkt_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Output stage drains in either state; held stable while full.
    always_comb begin
        wr_en_d     = wr_en_q;
        wr_data_d   = wr_data_q;
        stall_cnt_d = stall_cnt_q;
        if (accept) begin
            wr_en_d                    = 1'b1;
            wr_data_d                  = '0;
            wr_data_d[DATA_W-1:0]      = g_data;
            wr_data_d[LAST_B]          = g_last;
            wr_data_d[SRC_B +: SRC_W]  = grant_idx_q;
        end else if (wr_en_q && !fifo_wr_full) begin
            wr_en_d = 1'b0;
        end
        if (wr_en_q && fifo_wr_full && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            state_q        <= ARB_IDLE;
            rr_ptr_q       <= '0;
            grant_idx_q    <= '0;
            grant_active_q <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_data_q      <= '0;
            pkt_cnt_q      <= '0;
            stall_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_idx_q    <= grant_idx_d;
            grant_active_q <= grant_active_d;
            wr_en_q        <= wr_en_d;
            wr_data_q      <= wr_data_d;
            pkt_cnt_q      <= pkt_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign grant_active = grant_active_q;
    assign grant_idx    = grant_idx_q;
    assign pkt_count    = pkt_cnt_q;
    assign stall_count  = stall_cnt_q;

    a_hold_while_full: assert property (
        @(posedge wr_clk) disable iff (!wr_rst_n)
        (fifo_wr_en && fifo_wr_full) |=> $stable(fifo_wr_data)
    );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [3:0]   cfg, rv, rl, rr;
    logic [127:0] rd;
    logic         full, wen, ga;
    logic [34:0]  wdata;
    logic [1:0]   gidx;
    logic [15:0]  pktc, stc;

    logic [0:0]   cfg1, rv1, rl1, rr1;
    logic [7:0]   rd1;
    logic         full1, wen1, ga1;
    logic [9:0]   wdata1;
    logic [0:0]   gidx1;
    logic [1:0]   pktc1, stc1;

    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(32), .CNT_W(16)) dut (
        .wr_clk(clk), .wr_rst_n(rst_n), .cfg_enable(cfg), .req_valid(rv),
        .req_data(rd), .req_last(rl), .req_ready(rr), .fifo_wr_en(wen),
        .fifo_wr_data(wdata), .fifo_wr_full(full), .grant_active(ga),
        .grant_idx(gidx), .pkt_count(pktc), .stall_count(stc)
    );

    fifo_wr_arbiter #(.N_REQ(1), .DATA_W(8), .CNT_W(2)) dut1 (
        .wr_clk(clk), .wr_rst_n(rst_n), .cfg_enable(cfg1), .req_valid(rv1),
        .req_data(rd1), .req_last(rl1), .req_ready(rr1), .fifo_wr_en(wen1),
        .fifo_wr_data(wdata1), .fifo_wr_full(full1), .grant_active(ga1),
        .grant_idx(gidx1), .pkt_count(pktc1), .stall_count(stc1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // requester source model: beats left in current packet, queued packets
    int left[4], pkts[4], plen[4], seq[4];
    int pk1, seq1;

    logic [34:0] logd[$];
    int          logc[$];
    logic [9:0]  logd1[$];
    int          logc1[$];

    function automatic logic [31:0] bd(input int i, input int s);
        return {8'(i), 24'(s)};
    endfunction

    function automatic logic [34:0] tag(input int i, input int s, input bit last);
        return {2'(i), last, bd(i, s)};
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            rv[i] = (left[i] > 0);
            rl[i] = (left[i] == 1);
            rd[i*32 +: 32] = bd(i, seq[i]);
        end
        rv1 = (pk1 > 0);
        rl1 = 1'b1;
        rd1 = 8'(seq1);
    endtask

    task automatic tick();
        logic [3:0] a;
        logic [0:0] a1;
        @(negedge clk);
        a  = rv & rr;
        a1 = rv1 & rr1;
        if (wen && !full) begin logd.push_back(wdata); logc.push_back(cyc); end
        if (wen1 && !full1) begin logd1.push_back(wdata1); logc1.push_back(cyc); end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (a[i]) begin
                seq[i]++;
                left[i]--;
                if (left[i] == 0 && pkts[i] > 0) begin
                    pkts[i]--;
                    left[i] = plen[i];
                end
            end
        end
        if (a1[0]) begin seq1++; pk1--; end
        drive();
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            left[i] = 0; pkts[i] = 0; plen[i] = 0; seq[i] = 0;
        end
        pk1 = 0; seq1 = 0;
        logd.delete(); logc.delete(); logd1.delete(); logc1.delete();
        drive();
    endtask

    task automatic arm(input int i, input int npk, input int len);
        plen[i] = len; left[i] = len; pkts[i] = npk - 1;
        drive();
    endtask

    task automatic do_reset();
        clear_src();
        full = 1'b0; full1 = 1'b0; cfg = 4'hF; cfg1 = 1'b1;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [34:0] exp_t[5];
        logic [34:0] got;
        clear_src();
        full = 1'b0; full1 = 1'b0; cfg = 4'hF; cfg1 = 1'b1; rst_n = 1'b0;
        arm(0, 2, 1); arm(1, 1, 1); arm(2, 1, 1); arm(3, 1, 1);
        tick(); tick();
        #1;
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL rst_wen got=%0b exp=0", wen); end
        total++; if (wdata !== 35'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", wdata); end
        total++; if (rr !== 4'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0000", rr); end
        total++; if (ga !== 1'b0 || gidx !== 2'd0) begin bad++; $display("FAIL rst_grant got=%0b/%0d exp=0/0", ga, gidx); end
        total++; if (pktc !== 16'd0 || stc !== 16'd0) begin bad++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", pktc, stc); end
        rst_n = 1'b1;
        tick();
        total++; if (ga !== 1'b1 || gidx !== 2'd0) begin bad++; $display("FAIL first_grant got=%0b/%0d exp=1/0", ga, gidx); end
        for (int b = 0; b < 40 && logd.size() < 5; b++) tick();
        total++; if (logd.size() != 5) begin bad++; $display("FAIL rr_count got=%0d exp=5", logd.size()); end
        exp_t[0] = tag(0, 0, 1); exp_t[1] = tag(1, 0, 1); exp_t[2] = tag(2, 0, 1);
        exp_t[3] = tag(3, 0, 1); exp_t[4] = tag(0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            got = (i < logd.size()) ? logd[i] : 'x;
            total++; if (got !== exp_t[i]) begin bad++; $display("FAIL rr_order[%0d] got=%h exp=%h", i, got, exp_t[i]); end
        end
        tick(); tick();
        total++; if (pktc !== 16'd5) begin bad++; $display("FAIL rr_pktc got=%0d exp=5", pktc); end
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL rr_drain got=%0b exp=0", wen); end
    endtask

    task automatic test_packet();
        logic [34:0] exp_t[5];
        logic [34:0] got;
        int          dif;
        do_reset();
        arm(2, 1, 4);
        tick();
        total++; if (ga !== 1'b1 || gidx !== 2'd2) begin bad++; $display("FAIL pkt_grant got=%0b/%0d exp=1/2", ga, gidx); end
        arm(1, 1, 1);
        for (int b = 0; b < 40 && logd.size() < 5; b++) tick();
        exp_t[0] = tag(2, 0, 0); exp_t[1] = tag(2, 1, 0); exp_t[2] = tag(2, 2, 0);
        exp_t[3] = tag(2, 3, 1); exp_t[4] = tag(1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            got = (i < logd.size()) ? logd[i] : 'x;
            total++; if (got !== exp_t[i]) begin bad++; $display("FAIL pkt_beat[%0d] got=%h exp=%h", i, got, exp_t[i]); end
        end
        for (int i = 1; i < 5; i++) begin
            dif = (i < logc.size()) ? logc[i] - logc[i-1] : -1;
            total++; if (dif != ((i == 4) ? 2 : 1)) begin bad++; $display("FAIL pkt_spacing[%0d] got=%0d exp=%0d", i, dif, (i == 4) ? 2 : 1); end
        end
    endtask

    task automatic test_stall();
        logic [34:0] got;
        int          dif;
        do_reset();
        arm(0, 1, 4);
        tick(); tick(); tick();
        full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            total++; if (wen !== 1'b1) begin bad++; $display("FAIL stall_wen[%0d] got=%0b exp=1", k, wen); end
            total++; if (wdata !== tag(0, 1, 0)) begin bad++; $display("FAIL stall_hold[%0d] got=%h exp=%h", k, wdata, tag(0, 1, 0)); end
            total++; if (rr !== 4'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=0000", k, rr); end
            tick();
        end
        full = 1'b0;
        #1;
        total++; if (stc !== 16'd10) begin bad++; $display("FAIL stall_count got=%0d exp=10", stc); end
        for (int b = 0; b < 20 && logd.size() < 4; b++) tick();
        for (int i = 0; i < 4; i++) begin
            got = (i < logd.size()) ? logd[i] : 'x;
            total++; if (got !== tag(0, i, i == 3)) begin bad++; $display("FAIL stall_beat[%0d] got=%h exp=%h", i, got, tag(0, i, i == 3)); end
        end
        for (int i = 2; i < 4; i++) begin
            dif = (i < logc.size()) ? logc[i] - logc[i-1] : -1;
            total++; if (dif != 1) begin bad++; $display("FAIL stall_resume[%0d] got=%0d exp=1", i, dif); end
        end
        total++; if (stc !== 16'd10) begin bad++; $display("FAIL stall_final got=%0d exp=10", stc); end
    endtask

    task automatic test_cfg();
        logic [34:0] exp_t[6];
        logic [34:0] got;
        bit          cleared;
        do_reset();
        cfg = 4'b1011;
        arm(0, 2, 1); arm(1, 1, 3); arm(2, 1, 1); arm(3, 1, 1);
        cleared = 0;
        for (int b = 0; b < 40 && logd.size() < 6; b++) begin
            tick();
            if (!cleared && ga && gidx == 2'd1) begin cfg[1] = 1'b0; cleared = 1; end
        end
        exp_t[0] = tag(0, 0, 1); exp_t[1] = tag(1, 0, 0); exp_t[2] = tag(1, 1, 0);
        exp_t[3] = tag(1, 2, 1); exp_t[4] = tag(3, 0, 1); exp_t[5] = tag(0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            got = (i < logd.size()) ? logd[i] : 'x;
            total++; if (got !== exp_t[i]) begin bad++; $display("FAIL cfg_order[%0d] got=%h exp=%h", i, got, exp_t[i]); end
        end
        repeat (8) tick();
        total++; if (logd.size() != 6) begin bad++; $display("FAIL cfg_masked_writes got=%0d exp=6", logd.size()); end
        total++; if (ga !== 1'b0) begin bad++; $display("FAIL cfg_masked_grant got=%0b exp=0", ga); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        arm(1, 1, 1);
        for (int b = 0; b < 20 && logd.size() < 1; b++) tick();
        tick(); tick();
        arm(2, 1, 4);
        tick(); tick();
        full = 1'b1;
        tick();
        #1;
        total++; if (wen !== 1'b1 || stc !== 16'd1 || pktc !== 16'd1) begin
            bad++; $display("FAIL mid_setup got=en%0b/st%0d/pk%0d exp=en1/st1/pk1", wen, stc, pktc);
        end
        rst_n = 1'b0;
        arm(0, 1, 1); arm(3, 1, 1);
        tick();
        #1;
        total++; if (wen !== 1'b0) begin bad++; $display("FAIL mid_wen got=%0b exp=0", wen); end
        total++; if (ga !== 1'b0) begin bad++; $display("FAIL mid_grant got=%0b exp=0", ga); end
        total++; if (pktc !== 16'd0 || stc !== 16'd0) begin bad++; $display("FAIL mid_counters got=%0d/%0d exp=0/0", pktc, stc); end
        total++; if (wdata !== 35'd0) begin bad++; $display("FAIL mid_wdata got=%h exp=0", wdata); end
        rst_n = 1'b1;
        full = 1'b0;
        tick();
        total++; if (ga !== 1'b1 || gidx !== 2'd0) begin bad++; $display("FAIL mid_regrant got=%0b/%0d exp=1/0", ga, gidx); end
        total++; if (logd.size() != 1) begin bad++; $display("FAIL mid_discard got=%0d exp=1", logd.size()); end
    endtask

    task automatic test_single();
        logic [9:0] got;
        int         dif;
        do_reset();
        pk1 = 5;
        drive();
        for (int b = 0; b < 40 && logd1.size() < 5; b++) tick();
        for (int i = 0; i < 5; i++) begin
            got = (i < logd1.size()) ? logd1[i] : 'x;
            total++; if (got !== {1'b0, 1'b1, 8'(i)}) begin bad++; $display("FAIL n1_beat[%0d] got=%h exp=%h", i, got, {1'b0, 1'b1, 8'(i)}); end
        end
        for (int i = 1; i < 5; i++) begin
            dif = (i < logc1.size()) ? logc1[i] - logc1[i-1] : -1;
            total++; if (dif != 2) begin bad++; $display("FAIL n1_bubble[%0d] got=%0d exp=2", i, dif); end
        end
        tick(); tick();
        total++; if (pktc1 !== 2'd1) begin bad++; $display("FAIL n1_pkt_wrap got=%0d exp=1", pktc1); end
        total++; if (wen1 !== 1'b0 || gidx1 !== 1'b0) begin bad++; $display("FAIL n1_idle got=%0b/%0d exp=0/0", wen1, gidx1); end
        pk1 = 1;
        drive();
        tick(); tick();
        full1 = 1'b1;
        repeat (5) tick();
        #1;
        total++; if (stc1 !== 2'd3) begin bad++; $display("FAIL n1_stall_sat got=%0d exp=3", stc1); end
        total++; if (wen1 !== 1'b1 || wdata1 !== {1'b0, 1'b1, 8'd5}) begin
            bad++; $display("FAIL n1_hold got=%0b/%h exp=1/%h", wen1, wdata1, {1'b0, 1'b1, 8'd5});
        end
        full1 = 1'b0;
        tick(); tick();
        total++; if (logd1.size() != 6) begin bad++; $display("FAIL n1_release got=%0d exp=6", logd1.size()); end
    endtask

    initial begin
        rst_n = 1'b0; full = 1'b0; full1 = 1'b0; cfg = 4'hF; cfg1 = 1'b1;
        clear_src();
        test_reset();
        test_packet();
        test_stall();
        test_cfg();
        test_reset_mid();
        test_single();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares the single write port of async_fifo between N_REQ requesters on the write clock domain.
- Each requester presents a valid/ready stream. The arbiter grants one requester for a whole packet (up to and including the beat with last).
- Each beat is tagged with its source index and last flag, then driven into the FIFO through a registered output stage.
- fifo_wr_en never depends combinationally on fifo_wr_full.

Parameters:
- N_REQ, 4, number of requesters (>=1).
- DATA_W, 32, payload width per beat.
- SRC_W, (N_REQ>1 ? $clog2(N_REQ) : 1), source-tag width.
- CNT_W, 16, width of the statistics counters.

Ports:
- wr_clk  in  1  clock (FIFO write domain).
- wr_rst_n  in  1  synchronous active-low reset.
- cfg_enable  in  N_REQ  per-requester grant enable.
- req_valid  in  N_REQ  beat valid.
- req_data  in  N_REQ x DATA_W  beat payload.
- req_last  in  N_REQ  final beat of packet.
- req_ready  out  N_REQ  beat accepted when valid&&ready.
- fifo_wr_en  out  1  registered write request to FIFO.
- fifo_wr_data  out  SRC_W+1+DATA_W  {src, last, data}.
- fifo_wr_full  in  1  FIFO full; the write takes effect when fifo_wr_en && !fifo_wr_full.
- grant_active  out  1  a packet grant is held.
- grant_idx  out  SRC_W  currently/last granted requester.
- pkt_count  out  CNT_W  packets forwarded (wrapping).
- stall_count  out  CNT_W  cycles with fifo_wr_en && fifo_wr_full (saturating).

Behaviour:
- Reset (wr_rst_n low at posedge) values:
  - state=ARB_IDLE, rr_ptr=0, grant_idx=0, grant_active=0.
  - fifo_wr_en=0, fifo_wr_data=0, req_ready=0.
  - both counters=0.
  - Reset mid-packet discards the held output beat and the partial packet; the FIFO sees no further writes from it.
- FSM states: ARB_IDLE, ARB_XFER.
- ARB_IDLE:
  - Candidates are requesters with req_valid[i] && cfg_enable[i].
  - Pick the first candidate scanning i = rr_ptr, rr_ptr+1, ... mod N_REQ.
  - If one is found, register grant_idx and set grant_active=1, then go to ARB_XFER.
  - No beat is accepted in ARB_IDLE: req_ready is all 0.
- ARB_XFER, with g = grant_idx:
  - load = !fifo_wr_en || !fifo_wr_full.
  - req_ready[g] = load; all other req_ready bits are 0 (combinational from fifo_wr_full, which is allowed).
  - On req_valid[g] && req_ready[g], at the edge: fifo_wr_data <= {g, req_last[g], req_data[g]} and fifo_wr_en <= 1.
  - Else if fifo_wr_en && !fifo_wr_full, at the edge: fifo_wr_en <= 0.
  - Otherwise hold fifo_wr_en and fifo_wr_data stable (no change while full).
  - Accepted beat with req_last[g]=1: go to ARB_IDLE, set grant_active=0, rr_ptr <= (g+1) mod N_REQ, pkt_count++.
- The output register keeps draining in ARB_IDLE: fifo_wr_en <= 0 once the held beat is taken.
- Latency and throughput:
  - A request sees 1 cycle of arbitration, then first-beat acceptance.
  - A beat reaches fifo_wr_en 1 cycle after acceptance.
  - Inside a packet, 1 beat per cycle when the FIFO is not full.
  - There is exactly one bubble cycle between packets.
- Boundary conditions:
  - cfg_enable[g] dropping mid-packet does not abort the packet; it gates only new grants.
  - A requester dropping req_valid mid-packet keeps its grant; the arbiter waits indefinitely.
  - With fifo_wr_full high continuously, fifo_wr_data is held and stall_count increments every cycle until it saturates at all-ones.
  - N_REQ=1: rr_ptr stays 0, src=0.
  - No candidates: remain in ARB_IDLE.
  - pkt_count wraps from 2^CNT_W-1 to 0.
- Assertion: fifo_wr_data must not change while fifo_wr_en && fifo_wr_full.

Decomposition:
- Package fifo_arb_pkg holds:
  - arb_state_e (ARB_IDLE, ARB_XFER).
  - the tag layout constants (SRC_LSB, LAST_BIT).
  - a typedef for the tagged beat, parameterised by the width localparams.
- One sub-module: rr_pick.
  - Combinational round-robin priority pick: inputs request mask and start pointer; outputs found and index.
  - Reused by future read-side schedulers.

Test Plan:
- Reset with req_valid=4'b1111, then release reset.
  - Required: first grant is idx 0.
  - Required: packets are forwarded in order 0,1,2,3,0.
  - Required: src tags match.
  - Required: pkt_count=5 after five packets.
- Requester 2 sends a 4-beat packet (D0..D3, last on D3) while requester 1 is also valid.
  - Required: four consecutive FIFO writes tagged src=2.
  - Required: last bit set only on D3.
  - Required: requester 1 is granted only after D3.
- Hold fifo_wr_full=1 for 10 cycles during a packet.
  - Required: fifo_wr_en stays 1 with fifo_wr_data unchanged.
  - Required: req_ready[g]=0.
  - Required: stall_count=10.
  - Required: after release, the remaining beats flow one per cycle.
- cfg_enable=4'b1011 with all requesters valid.
  - Required: requester 2 is never granted; order is 0,1,3,0.
  - Clearing cfg_enable[1] during its packet: the packet still completes.
- Assert wr_rst_n=0 for 1 cycle mid-packet with fifo_wr_en=1 and fifo_wr_full=1.
  - Required: next cycle fifo_wr_en=0, grant_active=0, counters=0.
  - Required: next grant starts from idx 0.
- N_REQ=1, back-to-back single-beat packets.
  - Required: writes appear every other cycle (the bubble), all with src=0.
